// File: rtl/video_pkg.sv
// Shared video timing defaults and the encoding of who owns the frame-buffer RAM port.
package video_pkg;

    localparam int DEF_HDISPLAY = 800;
    localparam int DEF_VDISPLAY = 480;
    localparam int DEF_PIX_W    = 16;
    localparam int DEF_BUF_AW   = 19;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_WR   = 2'd2
    } owner_t;

endpackage

// File: rtl/video_delay_line.sv
// N-stage register delay for the {de, hsync, vsync} video control bundle.
// The syncs are active low, so they reset high.
module video_delay_line #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic de,
    input  logic hsync,
    input  logic vsync,
    output logic de_dly,
    output logic hsync_dly,
    output logic vsync_dly
);

    logic [STAGES-1:0] de_sr;
    logic [STAGES-1:0] hsync_sr;
    logic [STAGES-1:0] vsync_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_sr    <= '0;
            hsync_sr <= '1;
            vsync_sr <= '1;
        end else begin
            de_sr[0]    <= de;
            hsync_sr[0] <= hsync;
            vsync_sr[0] <= vsync;
            for (int i = 1; i < STAGES; i++) begin
                de_sr[i]    <= de_sr[i-1];
                hsync_sr[i] <= hsync_sr[i-1];
                vsync_sr[i] <= vsync_sr[i-1];
            end
        end
    end

    assign de_dly    = de_sr[STAGES-1];
    assign hsync_dly = hsync_sr[STAGES-1];
    assign vsync_dly = vsync_sr[STAGES-1];

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares a single-port frame-buffer RAM: scan-out reads own it during active video,
// drawing-engine writes use it in blanking, and the front buffer swaps at vblank start.
module fb_scanout_arbiter
    import video_pkg::*;
#(
    parameter int HDISPLAY = DEF_HDISPLAY,
    parameter int VDISPLAY = DEF_VDISPLAY,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int BUF_AW   = DEF_BUF_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       hpos,
    input  logic [11:0]       vpos,
    input  logic              data_enable,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              wr_valid,
    input  logic [BUF_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_sel,
    output logic [BUF_AW:0]   mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              pix_de,
    output logic              pix_hsync,
    output logic              pix_vsync,
    output logic [PIX_W-1:0]  pix_data
);

    // owner    | meaning
    // OWN_IDLE | nobody drives the RAM this cycle; address/data hold
    // OWN_DISP | scan-out read of the front buffer
    // OWN_WR   | drawing-engine write into the back buffer

    if ((64'd1 << BUF_AW) < 64'(HDISPLAY) * 64'(VDISPLAY)) begin : g_aw_check
        $error("BUF_AW cannot address one full frame");
    end

    localparam logic [11:0] VBLANK_LINE = 12'(VDISPLAY);

    owner_t            owner;
    logic [BUF_AW-1:0] disp_ptr;
    logic              swap_pending;
    logic              swap_now;
    logic              front_next;
    logic              de_d2;
    logic              hsync_d2;
    logic              vsync_d2;

    assign wr_ready   = wr_valid & ~data_enable & ~reset;
    assign swap_now   = (hpos == '0) && (vpos == VBLANK_LINE) && (swap_pending || swap_req);
    assign front_next = front_sel ^ swap_now;
    assign mem_we     = (owner == OWN_WR);

    // Writes target the complement of the post-swap front buffer, so a write
    // issued on the swap cycle still lands in what becomes the back buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            disp_ptr  <= '0;
        end else begin
            if (data_enable) begin
                owner    <= OWN_DISP;
                mem_addr <= {front_sel, disp_ptr};
            end else if (wr_valid) begin
                owner     <= OWN_WR;
                mem_addr  <= {~front_next, wr_addr};
                mem_wdata <= wr_data;
            end else begin
                owner <= OWN_IDLE;
            end

            if (vpos >= VBLANK_LINE) begin
                disp_ptr <= '0;
            end else if (data_enable) begin
                disp_ptr <= disp_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            front_sel <= front_next;
            swap_done <= swap_now;
            if (swap_now) begin
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    video_delay_line #(
        .STAGES(2)
    ) u_ctrl_dly (
        .clk      (clk),
        .reset    (reset),
        .de       (data_enable),
        .hsync    (hsync),
        .vsync    (vsync),
        .de_dly   (de_d2),
        .hsync_dly(hsync_d2),
        .vsync_dly(vsync_d2)
    );

    // RAM data for an address registered at edge N arrives for edge N+2,
    // matching the second delay stage; one more register keeps pix_* aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_de    <= 1'b0;
            pix_hsync <= 1'b1;
            pix_vsync <= 1'b1;
            pix_data  <= '0;
        end else begin
            pix_de    <= de_d2;
            pix_hsync <= hsync_d2;
            pix_vsync <= vsync_d2;
            pix_data  <= de_d2 ? mem_rdata : '0;
        end
    end

endmodule

// File: doc/fb_scanout_arbiter.md
# fb_scanout_arbiter

Shares one single-port synchronous frame-buffer RAM between display scan-out and a drawing-engine write port. Sits between the video timing generator and the panel: consumes its hpos/vpos/data_enable/hsync/vsync, issues pixel reads with absolute priority during active video, and grants writes in blanking. Manages double buffering, swapping the front buffer only at the start of vertical blanking.

## Interface
- HDISPLAY, 800: active pixels per line.
- VDISPLAY, 480: active lines per frame.
- PIX_W, 16: pixel width.
- BUF_AW, 19: word address width of one buffer; needs 2^BUF_AW >= HDISPLAY*VDISPLAY.

- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- hpos, vpos  in  12 each  timing-generator counters.
- data_enable  in  1  timing-generator active-video flag.
- hsync, vsync  in  1 each  timing-generator syncs, active low.
- wr_valid  in  1  write request.
- wr_addr  in  BUF_AW  pixel index within back buffer.
- wr_data  in  PIX_W  pixel value.
- wr_ready  out  1  write accepted this cycle.
- swap_req  in  1  one-cycle pulse: swap buffers at next vblank start.
- swap_done  out  1  one-cycle pulse when swap happens.
- front_sel  out  1  buffer currently displayed.
- mem_addr  out  BUF_AW+1  RAM address, MSB = buffer select.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  PIX_W  RAM write data.
- mem_rdata  in  PIX_W  RAM read data, valid one cycle after address.
- pix_de, pix_hsync, pix_vsync  out  1 each  delayed video controls.
- pix_data  out  PIX_W  pixel to panel; 0 when pix_de low.

## Operation
- Port owner FSM, registered: IDLE, DISP, WR. DISP when data_enable=1; else WR when wr_valid=1; else IDLE. Re-evaluated every cycle; no hold/hysteresis.
- wr_ready = wr_valid & ~data_enable & ~reset (combinational). Transfer when wr_valid & wr_ready at the edge.
- Display pointer disp_ptr (BUF_AW): cleared while vpos >= VDISPLAY; increments by 1 on each cycle data_enable=1. No multiplier.
- DISP cycle: mem_addr <= {front_sel, disp_ptr}, mem_we <= 0.
- WR cycle: mem_addr <= {~front_sel, wr_addr}, mem_we <= 1, mem_wdata <= wr_data. Writes never target the front buffer.
- IDLE: mem_we <= 0; mem_addr, mem_wdata hold.
- Swap: swap_req sets swap_pending. Swap point is the cycle with hpos==0 && vpos==VDISPLAY. At that cycle, if swap_pending or swap_req is high: front_sel toggles, swap_pending clears, swap_done pulses. swap_req on the swap cycle itself is honoured there. Repeated requests before a swap point merge into one swap.
- pix_data <= pix_de_stage ? mem_rdata : 0.

## Timing
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, front_sel=0, swap_done=0, pix_de=0, pix_hsync=1, pix_vsync=1, pix_data=0. Internal: disp_ptr=0, swap_pending=0, FSM=IDLE.
- Scan-out latency is 2 cycles. Inputs sampled at edge N appear on pix_* after edge N+2. hsync, vsync, and data_enable pass through a 2-stage delay so they stay aligned with pix_data.
- A write accepted at edge N drives mem_we=1 during cycle N..N+1. It is never blocked for more than one blanking interval.
- data_enable rising in the same cycle as wr_valid: display wins, wr_ready=0, and the writer holds.
- disp_ptr wraps only by clearing in vblank. Overflow past HDISPLAY*VDISPLAY-1 cannot occur with legal timing.
- Reset mid-frame: everything returns to reset values immediately (async). A pending swap is discarded. Scan-out resumes correctly from the next vblank.

## Structure
- Shared package `video_pkg`: HDISPLAY/VDISPLAY defaults, owner-state enum (IDLE, DISP, WR), PIX_W.
- One sub-module, `video_delay_line`: parameterised N-stage register delay for the {de, hsync, vsync} bundle. Resets de to 0 and syncs to 1.

## Test plan
- Reset, then run one frame with wr_valid=0. Expect mem_addr to step 0..383999 with MSB 0 during active cycles, and mem_we to stay 0. pix_data equals a RAM preloaded with value=addr[15:0], 2 cycles after data_enable.
- Hold wr_valid=1, wr_addr=5, wr_data=16'hABCD across an active line. Expect wr_ready=0 until the first cycle with data_enable=0. Then expect one cycle with mem_we=1, mem_addr={1,5}, mem_wdata=16'hABCD.
- Pulse swap_req at vpos=100. Expect front_sel 0→1 and swap_done=1 exactly at hpos=0, vpos=480. The next frame's reads use MSB 1 and writes use MSB 0.
- Pulse swap_req exactly at hpos=0, vpos=480. Expect an immediate swap. Pulse swap_req twice within one frame. Expect a single toggle.
- Assert reset at hpos=300, vpos=200 while swap_pending=1. Expect all outputs at reset values with no later swap_done. Expect pix_* alignment to be correct from the following frame.
- Checker across 3 frames with random wr_valid: pix_hsync/pix_vsync equal the inputs delayed by exactly 2 cycles, and no write ever hits MSB == front_sel.
